instruction_fetch_stage: RTL and testbench
==========================================

INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 The module SHALL declare parameter DATA_WIDTH, default 32: width of the PC, instruction and target buses.
REQ-002 The module SHALL declare parameter MEMORY_DEPTH, default 32: number of program memory words.
REQ-003 The module SHALL declare parameter TEXT_BASE, default 32'h0040_0000: PC reset value and byte address of program memory word 0.
REQ-004 The module SHALL provide port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The module SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL provide port Stall, input, 1 bit: hold the PC and IF/ID contents.
REQ-007 The module SHALL provide port Redirect, input, 1 bit: load the PC from RedirectTarget and flush IF/ID.
REQ-008 The module SHALL provide port RedirectTarget, input, DATA_WIDTH: absolute branch/jump byte address.
REQ-009 The module SHALL provide port Instruction, input, DATA_WIDTH: word returned by the program memory for InstrAddress.
REQ-010 The module SHALL provide port InstrAddress, output, DATA_WIDTH: combinational PC - TEXT_BASE, driven to the program memory Address input.
REQ-011 The module SHALL provide port IFID_Instruction, output, DATA_WIDTH: registered fetched instruction.
REQ-012 The module SHALL provide port IFID_PCPlus4, output, DATA_WIDTH: registered PC+4 of the fetched instruction.
REQ-013 The module SHALL provide port IFID_Valid, output, 1 bit: IF/ID holds a real instruction.
REQ-014 The module SHALL provide port FetchError, output, 1 bit: sticky flag set on a misaligned or out-of-range fetch.

Function
REQ-015 The FSM SHALL have exactly two states: RUN and HALT.
REQ-016 In RUN, edge priority SHALL be: reset > Redirect > Stall > normal advance.
REQ-017 On a normal advance, the stage SHALL load IFID_Instruction<=Instruction, IFID_PCPlus4<=PC+4, IFID_Valid<=1 and PC<=PC+4, giving one-cycle latency from PC to IF/ID.
REQ-018 On Stall without Redirect, PC and all IFID_* registers SHALL hold their values.
REQ-019 On Redirect (Stall ignored), the stage SHALL set PC<=RedirectTarget, IFID_Instruction<=32'h0000_0000 (NOP), IFID_PCPlus4<=0 and IFID_Valid<=0.
REQ-020 A PC SHALL be legal iff PC[1:0]==0 and TEXT_BASE <= PC < TEXT_BASE+4*MEMORY_DEPTH.
REQ-021 If the PC is illegal at a capturing edge (normal advance), the stage SHALL enter HALT, set FetchError<=1 and IFID_Valid<=0, and hold the PC.
REQ-022 An illegal RedirectTarget SHALL be loaded without error; the error SHALL be raised on the following capturing edge per REQ-021.
REQ-023 In HALT, all registers SHALL hold, Stall/Redirect SHALL be ignored, and only reset SHALL exit to RUN.
REQ-024 PC+4 SHALL wrap modulo 2^DATA_WIDTH, and the wrapped value SHALL then be illegal.
REQ-025 Sequential fetch past the last word (TEXT_BASE+4*MEMORY_DEPTH) SHALL trigger HALT per REQ-021.
REQ-026 InstrAddress SHALL be purely combinational from the PC, with no added register.

Reset
REQ-027 Synchronous reset SHALL force PC=TEXT_BASE, state=RUN, IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0 and FetchError=0.
REQ-028 Reset asserted mid-operation (during Stall, Redirect or HALT) SHALL override every other input on that edge.
REQ-029 In the cycle after reset deasserts, InstrAddress SHALL equal 0.

Structure
REQ-030 Shared package mips_fetch_pkg SHALL hold the TEXT_BASE default, the NOP constant (32'h0) and the fetch state enum {RUN, HALT}.
REQ-031 The PC register with load/hold/increment and legality check SHALL be a sub-module named pc_register; the IF/ID register and FSM SHALL stay in the top level.

Verification
REQ-032 Reset then 4 free-running cycles: InstrAddress sequence SHALL be 0,4,8,12, with IFID_PCPlus4 = 0x00400004, 0x00400008, 0x0040000C and IFID_Valid=1 from the first edge.
REQ-033 Stall high for 3 cycles at PC=0x00400008: PC and IF/ID SHALL be unchanged for 3 edges, then advancing SHALL resume at 0x0040000C.
REQ-034 Redirect with Stall both high, RedirectTarget=0x00400040: next cycle InstrAddress SHALL be 0x40, IFID_Valid=0 and IFID_Instruction=0.
REQ-035 Redirect to 0x00400042: the next edge SHALL set FetchError=1 and enter HALT; Redirect to 0x00400000 in HALT SHALL be ignored; reset SHALL clear FetchError.
REQ-036 Run 33 advances with MEMORY_DEPTH=32: the 32nd capture SHALL be valid, the 33rd edge SHALL set FetchError=1 with PC held at 0x00400080.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS instruction fetch stage: address map default,
// the flush instruction and the fetch controller states.
package mips_fetch_pkg;

   localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
   localparam logic [31:0] NOP               = 32'h0000_0000;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

endpackage : mips_fetch_pkg

// File: rtl/pc_register.sv
// Program counter with redirect load, sequential increment and hold, plus the
// legality check for the current fetch address.
module pc_register
   import mips_fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    MEMORY_DEPTH = 32,
   parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(TEXT_BASE_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_i,
   input  logic                  advance_i,
   input  logic [DATA_WIDTH-1:0] target_i,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic [DATA_WIDTH-1:0] pc_plus4_o,
   output logic                  legal_o
);

   // One extra bit so the end of the text segment cannot overflow the compare.
   localparam logic [DATA_WIDTH:0] TEXT_LIMIT =
      {1'b0, TEXT_BASE} + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] pc_d;

   // Increment wraps modulo 2^DATA_WIDTH; the wrapped value falls below TEXT_BASE.
   assign pc_plus4_o = pc_q + DATA_WIDTH'(4);

   assign legal_o = (pc_q[1:0] == 2'b00) &&
                    (pc_q >= TEXT_BASE) &&
                    ({1'b0, pc_q} < TEXT_LIMIT);

   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = target_i;
      end else if (advance_i) begin
         pc_d = pc_plus4_o;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= TEXT_BASE;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule : pc_register

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC sequencing, IF/ID pipeline register and a
// RUN/HALT controller that stops on the first illegal fetch address.
module instruction_fetch_stage
   import mips_fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    MEMORY_DEPTH = 32,
   parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(TEXT_BASE_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Stall,
   input  logic                  Redirect,
   input  logic [DATA_WIDTH-1:0] RedirectTarget,
   input  logic [DATA_WIDTH-1:0] Instruction,
   output logic [DATA_WIDTH-1:0] InstrAddress,
   output logic [DATA_WIDTH-1:0] IFID_Instruction,
   output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
   output logic                  IFID_Valid,
   output logic                  FetchError
);

   fetch_state_e          state_q, state_d;
   logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
   logic [DATA_WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
   logic                  ifid_valid_q, ifid_valid_d;
   logic                  fetch_error_q, fetch_error_d;

   logic                  pc_load;
   logic                  pc_advance;
   logic [DATA_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] pc_plus4;
   logic                  pc_legal;

   pc_register #(
      .DATA_WIDTH  (DATA_WIDTH),
      .MEMORY_DEPTH(MEMORY_DEPTH),
      .TEXT_BASE   (TEXT_BASE)
   ) u_pc (
      .clk       (clk),
      .reset     (reset),
      .load_i    (pc_load),
      .advance_i (pc_advance),
      .target_i  (RedirectTarget),
      .pc_o      (pc),
      .pc_plus4_o(pc_plus4),
      .legal_o   (pc_legal)
   );

   // NOTE: every _d takes its hold value first so no branch can infer a latch.
   always_comb begin
      state_d       = state_q;
      ifid_instr_d  = ifid_instr_q;
      ifid_pc4_d    = ifid_pc4_q;
      ifid_valid_d  = ifid_valid_q;
      fetch_error_d = fetch_error_q;
      pc_load       = 1'b0;
      pc_advance    = 1'b0;

      case (state_q)
         RUN: begin
            if (Redirect) begin
               pc_load      = 1'b1;
               ifid_instr_d = DATA_WIDTH'(NOP);
               ifid_pc4_d   = '0;
               ifid_valid_d = 1'b0;
            end else if (!Stall) begin
               if (pc_legal) begin
                  pc_advance   = 1'b1;
                  ifid_instr_d = Instruction;
                  ifid_pc4_d   = pc_plus4;
                  ifid_valid_d = 1'b1;
               end else begin
                  state_d       = HALT;
                  fetch_error_d = 1'b1;
                  ifid_valid_d  = 1'b0;
               end
            end
         end
         HALT: begin
            // Frozen until reset; Stall and Redirect have no effect here.
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= RUN;
         ifid_instr_q  <= DATA_WIDTH'(NOP);
         ifid_pc4_q    <= '0;
         ifid_valid_q  <= 1'b0;
         fetch_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ifid_instr_q  <= ifid_instr_d;
         ifid_pc4_q    <= ifid_pc4_d;
         ifid_valid_q  <= ifid_valid_d;
         fetch_error_q <= fetch_error_d;
      end
   end

   assign InstrAddress     = pc - TEXT_BASE;
   assign IFID_Instruction = ifid_instr_q;
   assign IFID_PCPlus4     = ifid_pc4_q;
   assign IFID_Valid       = ifid_valid_q;
   assign FetchError       = fetch_error_q;

endmodule : instruction_fetch_stage

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a combinational program memory
// whose word contents encode their own address.
module tb_instruction_fetch_stage;

   localparam int          DW   = 32;
   localparam int          DEPTH = 32;
   localparam logic [31:0] BASE = 32'h0040_0000;

   logic          clk = 1'b0;
   logic          reset;
   logic          stall;
   logic          redirect;
   logic [DW-1:0] redirect_target;
   logic [DW-1:0] instruction;
   logic [DW-1:0] instr_address;
   logic [DW-1:0] ifid_instruction;
   logic [DW-1:0] ifid_pcplus4;
   logic          ifid_valid;
   logic          fetch_error;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   instruction_fetch_stage #(
      .DATA_WIDTH  (DW),
      .MEMORY_DEPTH(DEPTH),
      .TEXT_BASE   (BASE)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .Stall           (stall),
      .Redirect        (redirect),
      .RedirectTarget  (redirect_target),
      .Instruction     (instruction),
      .InstrAddress    (instr_address),
      .IFID_Instruction(ifid_instruction),
      .IFID_PCPlus4    (ifid_pcplus4),
      .IFID_Valid      (ifid_valid),
      .FetchError      (fetch_error)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return {16'hC0DE, addr[15:0]};
   endfunction

   assign instruction = mem_word(instr_address);

   // Advance one clock and let outputs settle away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      redirect = 1'b0; stall = 1'b0;
      reset = 1'b1;
      tick();
      checks++; if (instr_address !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=%h", instr_address, 32'h0); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
      checks++; if (ifid_instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", ifid_instruction); end
      checks++; if (ifid_pcplus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got=%h exp=0", ifid_pcplus4); end
      checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", fetch_error); end
      reset = 1'b0;
   endtask

   task automatic test_sequential();
      do_reset();
      checks++; if (instr_address !== 32'h0) begin errors++; $display("FAIL seq_addr0 got=%h exp=0", instr_address); end
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++; if (instr_address !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, instr_address, 32'(4 * i)); end
         checks++; if (ifid_pcplus4 !== BASE + 32'(4 * i)) begin errors++; $display("FAIL seq_pc4[%0d] got=%h exp=%h", i, ifid_pcplus4, BASE + 32'(4 * i)); end
         checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, ifid_valid); end
         checks++; if (ifid_instruction !== mem_word(32'(4 * (i - 1)))) begin errors++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, ifid_instruction, mem_word(32'(4 * (i - 1)))); end
      end
   endtask

   task automatic test_stall();
      do_reset();
      tick();
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (instr_address !== 32'h8) begin errors++; $display("FAIL stall_addr[%0d] got=%h exp=%h", i, instr_address, 32'h8); end
         checks++; if (ifid_pcplus4 !== 32'h0040_0008) begin errors++; $display("FAIL stall_pc4[%0d] got=%h exp=%h", i, ifid_pcplus4, 32'h0040_0008); end
         checks++; if (ifid_instruction !== mem_word(32'h4)) begin errors++; $display("FAIL stall_instr[%0d] got=%h exp=%h", i, ifid_instruction, mem_word(32'h4)); end
         checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, ifid_valid); end
      end
      stall = 1'b0;
      tick();
      checks++; if (instr_address !== 32'hC) begin errors++; $display("FAIL stall_resume_addr got=%h exp=%h", instr_address, 32'hC); end
      checks++; if (ifid_pcplus4 !== 32'h0040_000C) begin errors++; $display("FAIL stall_resume_pc4 got=%h exp=%h", ifid_pcplus4, 32'h0040_000C); end
      checks++; if (ifid_instruction !== mem_word(32'h8)) begin errors++; $display("FAIL stall_resume_instr got=%h exp=%h", ifid_instruction, mem_word(32'h8)); end
   endtask

   task automatic test_redirect();
      redirect = 1'b1; stall = 1'b1; redirect_target = 32'h0040_0040;
      tick();
      redirect = 1'b0; stall = 1'b0;
      checks++; if (instr_address !== 32'h40) begin errors++; $display("FAIL redir_addr got=%h exp=%h", instr_address, 32'h40); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got=%b exp=0", ifid_valid); end
      checks++; if (ifid_instruction !== 32'h0) begin errors++; $display("FAIL redir_instr got=%h exp=0", ifid_instruction); end
      checks++; if (ifid_pcplus4 !== 32'h0) begin errors++; $display("FAIL redir_pc4 got=%h exp=0", ifid_pcplus4); end
      tick();
      checks++; if (instr_address !== 32'h44) begin errors++; $display("FAIL redir_next_addr got=%h exp=%h", instr_address, 32'h44); end
      checks++; if (ifid_pcplus4 !== 32'h0040_0044) begin errors++; $display("FAIL redir_next_pc4 got=%h exp=%h", ifid_pcplus4, 32'h0040_0044); end
      checks++; if (ifid_instruction !== mem_word(32'h40)) begin errors++; $display("FAIL redir_next_instr got=%h exp=%h", ifid_instruction, mem_word(32'h40)); end
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL redir_next_valid got=%b exp=1", ifid_valid); end
   endtask

   task automatic test_misaligned_halt();
      redirect = 1'b1; redirect_target = 32'h0040_0042;
      tick();
      redirect = 1'b0;
      checks++; if (instr_address !== 32'h42) begin errors++; $display("FAIL mis_load_addr got=%h exp=%h", instr_address, 32'h42); end
      checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL mis_load_err got=%b exp=0", fetch_error); end
      tick();
      checks++; if (fetch_error !== 1'b1) begin errors++; $display("FAIL mis_err got=%b exp=1", fetch_error); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL mis_valid got=%b exp=0", ifid_valid); end
      checks++; if (instr_address !== 32'h42) begin errors++; $display("FAIL mis_hold_addr got=%h exp=%h", instr_address, 32'h42); end
      redirect = 1'b1; redirect_target = BASE;
      tick();
      redirect = 1'b0;
      tick();
      checks++; if (instr_address !== 32'h42) begin errors++; $display("FAIL halt_ignore_addr got=%h exp=%h", instr_address, 32'h42); end
      checks++; if (fetch_error !== 1'b1) begin errors++; $display("FAIL halt_sticky_err got=%b exp=1", fetch_error); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got=%b exp=0", ifid_valid); end
      do_reset();
      checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL halt_reset_err got=%b exp=0", fetch_error); end
      checks++; if (instr_address !== 32'h0) begin errors++; $display("FAIL halt_reset_addr got=%h exp=0", instr_address); end
      tick();
      checks++; if (instr_address !== 32'h4) begin errors++; $display("FAIL halt_exit_addr got=%h exp=%h", instr_address, 32'h4); end
   endtask

   task automatic test_end_of_memory();
      do_reset();
      for (int k = 1; k <= DEPTH; k++) begin
         tick();
         checks++; if (ifid_valid !== 1'b1 || ifid_pcplus4 !== BASE + 32'(4 * k)) begin
            errors++; $display("FAIL eom_capture[%0d] valid=%b pc4=%h exp valid=1 pc4=%h", k, ifid_valid, ifid_pcplus4, BASE + 32'(4 * k));
         end
      end
      checks++; if (ifid_instruction !== mem_word(32'h7C)) begin errors++; $display("FAIL eom_last_instr got=%h exp=%h", ifid_instruction, mem_word(32'h7C)); end
      checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL eom_early_err got=%b exp=0", fetch_error); end
      tick();
      checks++; if (fetch_error !== 1'b1) begin errors++; $display("FAIL eom_err got=%b exp=1", fetch_error); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL eom_valid got=%b exp=0", ifid_valid); end
      checks++; if (instr_address !== 32'h80) begin errors++; $display("FAIL eom_pc_hold got=%h exp=%h", instr_address, 32'h80); end
      checks++; if (ifid_pcplus4 !== 32'h0040_0080) begin errors++; $display("FAIL eom_pc4_hold got=%h exp=%h", ifid_pcplus4, 32'h0040_0080); end
   endtask

   task automatic test_reset_override();
      // Still in HALT from the previous scenario; reset must beat Stall and Redirect.
      stall = 1'b1; redirect = 1'b1; redirect_target = 32'h0040_0020; reset = 1'b1;
      tick();
      reset = 1'b0; stall = 1'b0; redirect = 1'b0;
      checks++; if (instr_address !== 32'h0) begin errors++; $display("FAIL rst_ovr_addr got=%h exp=0", instr_address); end
      checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL rst_ovr_err got=%b exp=0", fetch_error); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_ovr_valid got=%b exp=0", ifid_valid); end
      tick();
      checks++; if (instr_address !== 32'h4 || ifid_valid !== 1'b1) begin
         errors++; $display("FAIL rst_ovr_run addr=%h valid=%b exp addr=4 valid=1", instr_address, ifid_valid);
      end
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_misaligned_halt();
      test_end_of_memory();
      test_reset_override();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_instruction_fetch_stage
